// File: rtl/lcd_char_receiver.sv
// HD44780-style 8-bit parallel LCD receiver: captures bus transfers on enable fall,
// decodes commands and characters into a 2x16 buffer with cursor and a registered read port.
`timescale 1ns/1ps
module lcd_char_receiver #(
  parameter int unsigned BUSY_CYCLES = 4
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic [7:0] lcd_data_i,
  input  logic       lcd_reset_i,
  input  logic       lcd_enable_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_char_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic [4:0] cursor_o,
  output logic       display_on_o,
  output logic       init_done_o,
  output logic       error_o
);

  localparam int unsigned BUSY_LOAD = (BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0;
  localparam int unsigned BCW       = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR, ST_BUSY} state_t;

  state_t         state;
  logic [7:0]     data_s1, data_s2, cap_data, cmd;
  logic           rs_s1, rs_s2, cap_rs, cmd_rs;
  logic           en_s1, en_s2, en_s2_q, fall_q;
  logic           fall;
  logic           entry_inc;
  logic [4:0]     clr_idx;
  logic [BCW-1:0] busy_cnt;
  logic [7:0]     char_buf [32];
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [7:0]     wr_data;

  assign fall = en_s2_q & ~en_s2;

  // Synchronizers plus a registered edge flag; data/RS are snapshotted with the edge.
  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      data_s1  <= '0;
      data_s2  <= '0;
      rs_s1    <= 1'b0;
      rs_s2    <= 1'b0;
      en_s1    <= 1'b0;
      en_s2    <= 1'b0;
      en_s2_q  <= 1'b0;
      fall_q   <= 1'b0;
      cap_data <= '0;
      cap_rs   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      data_s1 <= lcd_data_i;
      data_s2 <= data_s1;
      rs_s1   <= lcd_reset_i;
      rs_s2   <= rs_s1;
      en_s1   <= lcd_enable_i;
      en_s2   <= en_s1;
      en_s2_q <= en_s2;
      fall_q  <= fall;
      if (fall) begin
        cap_data <= data_s2;
        cap_rs   <= rs_s2;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      state        <= ST_IDLE;
      cmd          <= '0;
      cmd_rs       <= 1'b0;
      cursor_o     <= '0;
      entry_inc    <= 1'b1;
      display_on_o <= 1'b0;
      init_done_o  <= 1'b0;
      error_o      <= 1'b0;
      valid_o      <= 1'b0;
      busy_o       <= 1'b0;
      clr_idx      <= '0;
      busy_cnt     <= '0;
    end else begin
      valid_o <= 1'b0;
      if (state != ST_IDLE && fall_q) error_o <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (fall_q) begin
            cmd    <= cap_data;
            cmd_rs <= cap_rs;
            busy_o <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          valid_o  <= 1'b1;
          state    <= ST_BUSY;
          busy_cnt <= BCW'(BUSY_LOAD);
          if (cmd_rs) begin
            cursor_o <= entry_inc ? cursor_o + 5'd1 : cursor_o - 5'd1;
          end else begin
            casez (cmd)
              8'b1???????: begin
                if (cmd[6:4] == 3'b000)      cursor_o <= {1'b0, cmd[3:0]};
                else if (cmd[6:4] == 3'b100) cursor_o <= {1'b1, cmd[3:0]};
                else                         error_o  <= 1'b1;
              end
              8'b001?????: init_done_o <= 1'b1;
              8'b0001????: begin
                if (!cmd[3]) cursor_o <= cmd[2] ? cursor_o + 5'd1 : cursor_o - 5'd1;
              end
              8'b00001???: display_on_o <= cmd[2];
              8'b000001??: entry_inc    <= cmd[1];
              8'b0000001?: cursor_o     <= '0;
              8'b00000001: begin
                cursor_o  <= '0;
                entry_inc <= 1'b1;
                clr_idx   <= 5'd1;
                state     <= ST_CLEAR;
              end
              // CGRAM address and 0x00 execute as no-ops.
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          // Index 0 was written in EXEC; the wrap of clr_idx back to 0 marks the 32nd cycle.
          if (clr_idx == 5'd0) begin
            state    <= ST_BUSY;
            busy_cnt <= BCW'(BUSY_LOAD);
          end else begin
            clr_idx <= clr_idx + 5'd1;
          end
        end
        ST_BUSY: begin
          if (busy_cnt == '0) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_en   = 1'b0;
    wr_addr = cursor_o;
    wr_data = cmd;
    if (state == ST_EXEC && cmd_rs) begin
      wr_en = 1'b1;
    end else if (state == ST_EXEC && cmd == 8'h01) begin
      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 8'h20;
    end else if (state == ST_CLEAR && clr_idx != 5'd0) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = 8'h20;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      // NOTE: the buffer is built from resettable flops because reset must show a blank display at once.
      for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
      rd_char_o <= '0;
    end else begin
      rd_char_o <= char_buf[rd_addr_i];
      if (wr_en) char_buf[wr_addr] <= wr_data;
    end
  end

endmodule
